// File: rtl/i2c_pkg.sv
// Shared FSM state encoding and bus-level constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus line plus rise/fall detection on the synced value.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  // Preloaded high: an idle bus reads high, so reset creates no false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;
  assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write-byte receive, read-byte transmit with clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       scl_oe,
  output logic       sda_o,
  output logic       sda_oe,
  output logic       start,
  output logic       stop,
  output logic       addr_hit,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       tx_nack,
  output i2c_state_e state_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk(clk), .rst(rst), .d_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk(clk), .rst(rst), .d_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q, rx_data_q;
  logic       scl_oe_q, sda_oe_q, tx_req_q, rw_q;
  logic       start_q, stop_q, addr_hit_q, rx_valid_q, tx_nack_q;

  logic       start_det, stop_det;
  logic [7:0] shift_in;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign shift_in  = {shift_q[6:0], sda_lvl};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      addr_hit_q <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_nack_q  <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      addr_hit_q <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_nack_q  <= 1'b0;
      // Bus conditions override everything, including a same-cycle tx_valid.
      if (start_det) begin
        state_q  <= ADDR;
        cnt_q    <= 4'd0;
        scl_oe_q <= 1'b0;
        sda_oe_q <= 1'b0;
        tx_req_q <= 1'b0;
        start_q  <= 1'b1;
      end else if (stop_det) begin
        state_q  <= IDLE;
        cnt_q    <= 4'd0;
        scl_oe_q <= 1'b0;
        sda_oe_q <= 1'b0;
        tx_req_q <= 1'b0;
        stop_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR, WR_DATA: begin
            if (scl_rise) begin
              shift_q <= shift_in;
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                cnt_q <= 4'd0;
                if (state_q == ADDR) begin
                  if (shift_in[7:1] == I2C_ADDR) begin
                    addr_hit_q <= 1'b1;
                    rw_q       <= shift_in[0];
                    state_q    <= ADDR_ACK;
                  end else begin
                    state_q <= IDLE;
                  end
                end else begin
                  rx_data_q  <= shift_in;
                  rx_valid_q <= 1'b1;
                  state_q    <= WR_ACK;
                end
              end
            end
          end
          // First scl fall starts the ACK, the next one ends it.
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= (state_q == ADDR_ACK && rw_q) ? RD_LOAD : WR_DATA;
              end
            end
          end
          RD_LOAD: begin
            if (tx_req_q && tx_valid) begin
              shift_q  <= tx_data;
              sda_oe_q <= ~tx_data[7];
              tx_req_q <= 1'b0;
              scl_oe_q <= 1'b0;
              cnt_q    <= 4'd0;
              state_q  <= RD_DATA;
            end else if (!tx_req_q && !scl_lvl) begin
              tx_req_q <= 1'b1;
              scl_oe_q <= 1'b1;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= 4'd0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q <= ~shift_q[3'd7 - cnt_q[2:0]];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_NACK) begin
                tx_nack_q <= 1'b1;
                state_q   <= IDLE;
              end else begin
                state_q <= RD_LOAD;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign scl_oe   = scl_oe_q;
  assign scl_o    = ~scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign sda_o    = ~sda_oe_q;
  assign start    = start_q;
  assign stop     = stop_q;
  assign addr_hit = addr_hit_q;
  assign rw       = rw_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign tx_nack  = tx_nack_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an open-drain initiator model, a tx responder and bus monitors.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 20;

  logic       clk, rst;
  logic       m_scl, m_sda;
  logic       scl_bus, sda_bus;
  logic       scl_o, scl_oe, sda_o, sda_oe;
  logic       start, stop, addr_hit, rw, rx_valid, tx_req, tx_nack, tx_valid;
  logic [7:0] rx_data, tx_data;
  i2c_state_e dut_state;

  assign scl_bus = m_scl & ~(scl_oe & ~scl_o);
  assign sda_bus = m_sda & ~(sda_oe & ~sda_o);

  i2c_target #(.I2C_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst),
    .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .scl_oe(scl_oe), .sda_o(sda_o), .sda_oe(sda_oe),
    .start(start), .stop(stop), .addr_hit(addr_hit), .rw(rw),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req), .tx_nack(tx_nack),
    .state_o(dut_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // monitors
  int n_start, n_stop, n_hit, n_rxv, n_nack, n_txreq, n_sda_low;
  int oe_run, last_oe_run;
  logic [7:0] last_rx;
  logic       last_rw, tx_req_prev;

  initial begin
    n_start = 0; n_stop = 0; n_hit = 0; n_rxv = 0; n_nack = 0; n_txreq = 0;
    n_sda_low = 0; oe_run = 0; last_oe_run = 0; last_rx = 8'h00; last_rw = 1'b0;
    tx_req_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (start)    n_start <= n_start + 1;
    if (stop)     n_stop  <= n_stop + 1;
    if (addr_hit) begin n_hit <= n_hit + 1; last_rw <= rw; end
    if (rx_valid) begin n_rxv <= n_rxv + 1; last_rx <= rx_data; end
    if (tx_nack)  n_nack  <= n_nack + 1;
    if (sda_oe)   n_sda_low <= n_sda_low + 1;
    if (tx_req && !tx_req_prev) n_txreq <= n_txreq + 1;
    tx_req_prev <= tx_req;
    if (scl_oe) oe_run <= oe_run + 1;
    else begin
      if (oe_run != 0) last_oe_run <= oe_run;
      oe_run <= 0;
    end
  end

  // tx responder: answers each tx_req with the next table byte after tx_delay cycles
  logic [7:0] tx_tbl [8];
  int tx_delay;
  int rsp_idx;

  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rsp_idx  = 0;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        repeat (tx_delay) @(negedge clk);
        tx_data  = tx_tbl[rsp_idx];
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rsp_idx++;
      end
    end
  end

  // scoreboard
  int checks, errors, timeouts;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    exp_q.push_back(expv);
    assert (obs === exp_q.pop_front()) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high();
    int n;
    n = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeouts++;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;
    wait_q();
    scl_high();
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1;
    wait_q();
    scl_high();
    wait_q();
    b = sda_bus;
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    scl_high();
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    scl_high();
    wait_q();
    m_sda = 1'b1;
    wait_q();
  endtask

  task automatic chk_released(input string tag);
    chk({tag, " state"}, 32'(dut_state), 32'(IDLE));
    chk({tag, " scl_o/oe"}, {30'd0, scl_o, scl_oe}, 32'h2);
    chk({tag, " sda_o/oe"}, {30'd0, sda_o, sda_oe}, 32'h2);
    chk({tag, " tx_req"}, 32'(tx_req), 32'h0);
  endtask

  int b_start, b_stop, b_hit, b_rxv, b_nack, b_txreq, b_sda_low;

  task automatic snap();
    b_start = n_start; b_stop = n_stop; b_hit = n_hit; b_rxv = n_rxv;
    b_nack = n_nack; b_txreq = n_txreq; b_sda_low = n_sda_low;
  endtask

  // directed sequence
  initial begin
    logic ack;
    logic b;
    logic [7:0] d;
    checks = 0; errors = 0; timeouts = 0;
    tx_tbl[0] = 8'h3C; tx_tbl[1] = 8'hC3; tx_tbl[2] = 8'h96; tx_tbl[3] = 8'h5A;
    tx_tbl[4] = 8'h00; tx_tbl[5] = 8'h00; tx_tbl[6] = 8'h00; tx_tbl[7] = 8'h00;
    tx_delay = 3;
    m_scl = 1'b1;
    m_sda = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // reset state
    chk_released("reset");
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset rw", 32'(rw), 32'h0);
    chk("reset pulses", {27'd0, start, stop, addr_hit, rx_valid, tx_nack}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no false start", 32'(n_start), 32'h0);

    // write A0, A5, STOP
    snap();
    i2c_start();
    write_byte(8'hA0, ack);
    chk("wr addr ack", 32'(ack), 32'h0);
    write_byte(8'hA5, ack);
    chk("wr data ack", 32'(ack), 32'h0);
    i2c_stop();
    chk("wr addr_hit", 32'(n_hit - b_hit), 32'd1);
    chk("wr rw", 32'(last_rw), 32'h0);
    chk("wr rx_valid", 32'(n_rxv - b_rxv), 32'd1);
    chk("wr rx_data", 32'(last_rx), 32'hA5);
    chk("wr start", 32'(n_start - b_start), 32'd1);
    chk("wr stop", 32'(n_stop - b_stop), 32'd1);
    chk_released("wr end");

    // wrong address 0x51
    snap();
    i2c_start();
    write_byte(8'hA2, ack);
    chk("miss addr nack", 32'(ack), 32'h1);
    write_byte(8'h55, ack);
    chk("miss data nack", 32'(ack), 32'h1);
    i2c_stop();
    chk("miss sda low", 32'(n_sda_low - b_sda_low), 32'd0);
    chk("miss addr_hit", 32'(n_hit - b_hit), 32'd0);
    chk("miss rx_valid", 32'(n_rxv - b_rxv), 32'd0);

    // read two bytes, ACK then NACK
    snap();
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rd addr ack", 32'(ack), 32'h0);
    read_byte(d, 1'b0);
    chk("rd byte0", 32'(d), 32'h3C);
    read_byte(d, 1'b1);
    chk("rd byte1", 32'(d), 32'hC3);
    i2c_stop();
    chk("rd rw", 32'(last_rw), 32'h1);
    chk("rd tx_req count", 32'(n_txreq - b_txreq), 32'd2);
    chk("rd tx_nack count", 32'(n_nack - b_nack), 32'd1);
    chk_released("rd end");

    // read with a 50-cycle late tx_valid
    tx_delay = 50;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("slow addr ack", 32'(ack), 32'h0);
    read_byte(d, 1'b1);
    chk("slow byte", 32'(d), 32'h96);
    chk("slow stretch>=50", 32'(last_oe_run >= 50), 32'h1);
    i2c_stop();
    tx_delay = 3;

    // write then repeated START into a read
    snap();
    i2c_start();
    write_byte(8'hA0, ack);
    chk("rs wr ack", 32'(ack), 32'h0);
    write_byte(8'h07, ack);
    chk("rs data ack", 32'(ack), 32'h0);
    chk("rs rw before", 32'(rw), 32'h0);
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rs rd addr ack", 32'(ack), 32'h0);
    chk("rs rw after", 32'(rw), 32'h1);
    read_byte(d, 1'b1);
    chk("rs rd byte", 32'(d), 32'h5A);
    i2c_stop();
    chk("rs start count", 32'(n_start - b_start), 32'd2);
    chk("rs rx_data", 32'(last_rx), 32'h07);
    chk("rs addr_hit", 32'(n_hit - b_hit), 32'd2);

    // STOP after 4 bits of a data byte
    i2c_start();
    write_byte(8'hA0, ack);
    chk("abort addr ack", 32'(ack), 32'h0);
    snap();
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    chk("abort stop", 32'(n_stop - b_stop), 32'd1);
    chk("abort rx_valid", 32'(n_rxv - b_rxv), 32'd0);
    chk_released("abort");

    // reset in the middle of a read, then bus activity without START
    tx_delay = 0;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rstrd addr ack", 32'(ack), 32'h0);
    d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    chk("rstrd bits", 32'(d), 32'hF8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_released("rstrd");
    chk("rstrd rw", 32'(rw), 32'h0);
    snap();
    for (int i = 0; i < 5; i++) read_bit(b);
    write_bit(1'b1);
    chk("rstrd ignored sda", 32'(n_sda_low - b_sda_low), 32'd0);
    chk("rstrd ignored state", 32'(dut_state), 32'(IDLE));
    i2c_stop();
    chk("rstrd no rx_valid", 32'(n_rxv - b_rxv), 32'd0);
    i2c_start();
    write_byte(8'hA0, ack);
    chk("recover ack", 32'(ack), 32'h0);
    i2c_stop();

    chk("scl wait timeouts", 32'(timeouts), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
